regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Arbitrates the single write port of the 8×8-bit register file between two writeback sources: the ALU (single-cycle results) and the data-memory load path (results that return after a BUSYWAIT stall). Each source has a small FIFO with a valid/ready handshake. A round-robin arbiter drains both FIFOs into one registered write stage that drives the register file's WRITEENABLE/WRITEREG/WRITEDATA and holds while BUSYWAIT is high. A per-register PENDING vector gives the control unit what it needs for read-after-write stall decisions.

## Interface
- DATA_W, 8, writeback data width
- ADDR_W, 3, register index width (PENDING width = 2**ADDR_W)
- DEPTH, 2, entries per source FIFO (power of 2, ≥2)

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- A_VALID  in  1  ALU writeback request
- A_REG  in  ADDR_W  ALU destination register
- A_DATA  in  DATA_W  ALU result
- A_READY  out  1  ALU FIFO can accept
- M_VALID  in  1  memory load writeback request
- M_REG  in  ADDR_W  load destination register
- M_DATA  in  DATA_W  load data
- M_READY  out  1  memory FIFO can accept
- BUSYWAIT  in  1  register file ignores writes while high
- WRITEENABLE  out  1  write strobe to register file
- WRITEREG  out  ADDR_W  write address to register file
- WRITEDATA  out  DATA_W  write data to register file
- PENDING  out  2**ADDR_W  bit r set while any queued or staged write targets register r

## Operation
- Push: at a rising edge where X_VALID && X_READY, {X_REG, X_DATA} is appended to FIFO X. X_READY = !full(X). There is no same-cycle bypass, so a full FIFO refuses a push even when it pops on that edge.
- Write stage: one entry, shown on WRITEENABLE/WRITEREG/WRITEDATA.
  - The stage is "consumed" at an edge where WRITEENABLE=1 and BUSYWAIT=0.
  - The stage may load at an edge where it is empty (WRITEENABLE=0) or is being consumed.
  - When it may load and at least one FIFO is non-empty, the winner's head pops into the stage and WRITEENABLE=1. Otherwise WRITEENABLE becomes 0 and WRITEREG/WRITEDATA hold their previous values.
  - When BUSYWAIT=1 and WRITEENABLE=1, all three outputs hold unchanged.
- Arbitration, state LAST ∈ {ALU, MEM}:
  - Only one FIFO non-empty: it wins.
  - Both non-empty: the source other than LAST wins.
  - LAST updates to the winner on every pop.
  - Order within a source is preserved. Order across sources follows grant order only.
- Same register targeted by both sources: both writes are performed in grant order, and the later grant's data remains in the register.
- PENDING = OR over valid FIFO entries of onehot(reg) | (WRITEENABLE ? onehot(WRITEREG) : 0). It is combinational from registered state only, with no path from the inputs.
- FIFO occupancy counters are ADDR-width-safe, with pointers that wrap modulo DEPTH. A push and a pop on the same edge of a non-full, non-empty FIFO leave the count unchanged.

## Timing
- Reset (RESET=0, asynchronous):
  - All FIFOs are emptied and LAST=MEM.
  - WRITEENABLE=0, WRITEREG=0, WRITEDATA=0, PENDING=0.
  - A_READY=0 and M_READY=0 while RESET is low. Both become 1 in the first cycle after release.
- Reset mid-operation: queued and staged writes are discarded. No write strobe is asserted after RESET falls.
- Latency with both FIFOs empty, stage idle, BUSYWAIT=0:
  - Push accepted at edge N.
  - WRITEENABLE=1 after edge N+1.
  - The register file captures the write at edge N+2.
- Throughput: one register write per cycle while BUSYWAIT=0 and data is queued.
- BUSYWAIT held high for k edges extends the stage's residency by exactly k cycles. The FIFOs keep accepting pushes until full.
- A PENDING bit sets in the cycle after the push edge. It clears in the cycle after the consuming edge, unless another entry for the same register is still queued.

## Test plan
- Single write: after reset, ALU push (reg 3, 0x5A) at edge N → WRITEENABLE=1, WRITEREG=3, WRITEDATA=0x5A during cycle N+1..N+2; PENDING=0x08 from N+1 until after edge N+2, then 0x00.
- Round-robin: both FIFOs preloaded with 2 entries (ALU r1=0x11, r2=0x22; MEM r4=0x44, r5=0x55), BUSYWAIT=0 → write order r1, r4, r2, r5 on consecutive cycles.
- BUSYWAIT stall: stage holds (r6, 0x66) with BUSYWAIT=1 for 3 edges → outputs are stable for those 3 edges and consumed at the 4th. Meanwhile the ALU FIFO fills, A_READY drops to 0 after DEPTH pushes, and A_VALID held high loses no data.
- Same-register conflict: ALU (r2, 0xAA) and MEM (r2, 0xBB) pushed on the same edge with LAST=MEM → the ALU write goes first, and register 2 ends at 0xBB. PENDING[2] stays 1 until the second write is consumed.
- Reset mid-operation: FIFOs half-full, stage loaded, RESET pulsed low between edges → WRITEENABLE and PENDING go to 0 immediately and asynchronously. No further writes occur, and READY returns to 1 one cycle after release.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the ALU/load sources, the write arbiter and the register file port.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic                    A_VALID;
    logic [ADDR_W-1:0]       A_REG;
    logic [DATA_W-1:0]       A_DATA;
    logic                    A_READY;
    logic                    M_VALID;
    logic [ADDR_W-1:0]       M_REG;
    logic [DATA_W-1:0]       M_DATA;
    logic                    M_READY;
    logic                    BUSYWAIT;
    logic                    WRITEENABLE;
    logic [ADDR_W-1:0]       WRITEREG;
    logic [DATA_W-1:0]       WRITEDATA;
    logic [(1<<ADDR_W)-1:0]  PENDING;

    modport master (
        output A_VALID, A_REG, A_DATA, M_VALID, M_REG, M_DATA, BUSYWAIT,
        input  A_READY, M_READY, WRITEENABLE, WRITEREG, WRITEDATA, PENDING
    );

    modport slave (
        input  A_VALID, A_REG, A_DATA, M_VALID, M_REG, M_DATA, BUSYWAIT,
        output A_READY, M_READY, WRITEENABLE, WRITEREG, WRITEDATA, PENDING
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbitration of ALU and load writebacks onto the single register-file write port.
module regfile_write_arbiter_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    push,
    input  logic [ADDR_W-1:0]       push_reg,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic                    empty,
    output logic                    full,
    output logic [ADDR_W-1:0]       head_reg,
    output logic [DATA_W-1:0]       head_data,
    output logic [(1<<ADDR_W)-1:0]  pend
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  pend_idx;

    always_ff @(posedge CLK) begin
        if (push) begin
            reg_mem[wr_ptr]  <= push_reg;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head_reg  = reg_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Only slots between rd_ptr and rd_ptr+count hold live entries.
    always_comb begin
        pend     = '0;
        pend_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) pend[reg_mem[pend_idx]] = 1'b1;
        end
    end
endmodule

// state    | meaning
// SRC_ALU  | last pop came from the ALU FIFO; MEM wins a tie
// SRC_MEM  | last pop came from the load FIFO (reset); ALU wins a tie
module regfile_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    regfile_write_arbiter_if.slave bus
);
    localparam int PEND_W = 1 << ADDR_W;

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_t;

    src_t               last_q;
    src_t               last_d;
    logic               rdy_en_q;
    logic               a_empty, a_full, m_empty, m_full;
    logic               a_push, m_push;
    logic               pop_a, pop_m;
    logic               consume, can_load;
    logic [ADDR_W-1:0]  a_head_reg, m_head_reg;
    logic [DATA_W-1:0]  a_head_data, m_head_data;
    logic [PEND_W-1:0]  a_pend, m_pend, stage_pend;
    logic               we_q;
    logic [ADDR_W-1:0]  wreg_q;
    logic [DATA_W-1:0]  wdata_q;

    // READY stays low through reset and rises on the first edge after release.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) rdy_en_q <= 1'b0;
        else        rdy_en_q <= 1'b1;
    end

    assign bus.A_READY = rdy_en_q && !a_full;
    assign bus.M_READY = rdy_en_q && !m_full;
    assign a_push      = bus.A_VALID && bus.A_READY;
    assign m_push      = bus.M_VALID && bus.M_READY;

    regfile_write_arbiter_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_alu_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (a_push),
        .push_reg  (bus.A_REG),
        .push_data (bus.A_DATA),
        .pop       (pop_a),
        .empty     (a_empty),
        .full      (a_full),
        .head_reg  (a_head_reg),
        .head_data (a_head_data),
        .pend      (a_pend)
    );

    regfile_write_arbiter_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (m_push),
        .push_reg  (bus.M_REG),
        .push_data (bus.M_DATA),
        .pop       (pop_m),
        .empty     (m_empty),
        .full      (m_full),
        .head_reg  (m_head_reg),
        .head_data (m_head_data),
        .pend      (m_pend)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) last_q <= SRC_MEM;
        else        last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (pop_a)      last_d = SRC_ALU;
        else if (pop_m) last_d = SRC_MEM;
    end

    always_comb begin
        consume  = we_q && !bus.BUSYWAIT;
        can_load = !we_q || consume;
        pop_a    = 1'b0;
        pop_m    = 1'b0;
        if (can_load) begin
            if (!a_empty && (m_empty || last_q == SRC_MEM)) pop_a = 1'b1;
            else if (!m_empty)                              pop_m = 1'b1;
        end
    end

    // Address/data hold their last values when the stage drains empty.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else if (can_load) begin
            if (pop_a) begin
                we_q    <= 1'b1;
                wreg_q  <= a_head_reg;
                wdata_q <= a_head_data;
            end else if (pop_m) begin
                we_q    <= 1'b1;
                wreg_q  <= m_head_reg;
                wdata_q <= m_head_data;
            end else begin
                we_q    <= 1'b0;
            end
        end
    end

    always_comb begin
        stage_pend = '0;
        if (we_q) stage_pend[wreg_q] = 1'b1;
    end

    assign bus.WRITEENABLE = we_q;
    assign bus.WRITEREG    = wreg_q;
    assign bus.WRITEDATA   = wdata_q;
    assign bus.PENDING     = a_pend | m_pend | stage_pend;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a write-order scoreboard on the register-file port.
module tb_regfile_write_arbiter;
    logic CLK;
    logic RESET;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   wr_count = 0;
    int   wlog[$];
    logic [10:0] sb_q[$];
    logic [7:0]  rf[8];

    regfile_write_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus();

    regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3), .DEPTH(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n = 0;
        while (sb_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk(tag, sb_q.size(), 0);
        tick();
    endtask

    // Every write the register file will capture on the next edge must match the scoreboard head.
    always @(negedge CLK) begin
        if (bus.WRITEENABLE === 1'b1 && bus.BUSYWAIT === 1'b0) begin
            logic [10:0] exp;
            chk("sb_avail", (sb_q.size() > 0) ? 1 : 0, 1);
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                chk("write_order", {bus.WRITEREG, bus.WRITEDATA}, exp);
            end
            rf[bus.WRITEREG] = bus.WRITEDATA;
            wlog.push_back(cyc);
            wr_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        int n;
        int wc;
        logic acc;

        RESET = 1'b0;
        bus.A_VALID = 0; bus.A_REG = 0; bus.A_DATA = 0;
        bus.M_VALID = 0; bus.M_REG = 0; bus.M_DATA = 0;
        bus.BUSYWAIT = 0;
        #2;
        chk("rst_we",    bus.WRITEENABLE, 0);
        chk("rst_wreg",  bus.WRITEREG, 0);
        chk("rst_wdata", bus.WRITEDATA, 0);
        chk("rst_pend",  bus.PENDING, 0);
        chk("rst_ardy",  bus.A_READY, 0);
        chk("rst_mrdy",  bus.M_READY, 0);
        tick(); tick();
        #2 RESET = 1'b1;
        chk("rel_ardy_low", bus.A_READY, 0);
        tick();
        chk("rel_ardy", bus.A_READY, 1);
        chk("rel_mrdy", bus.M_READY, 1);

        // single ALU write
        bus.A_VALID = 1; bus.A_REG = 3; bus.A_DATA = 8'h5A;
        sb_q.push_back({3'd3, 8'h5A});
        tick();
        bus.A_VALID = 0;
        chk("single_pend_n", bus.PENDING, 8'h08);
        chk("single_we_n",   bus.WRITEENABLE, 0);
        tick();
        chk("single_we",    bus.WRITEENABLE, 1);
        chk("single_wreg",  bus.WRITEREG, 3);
        chk("single_wdata", bus.WRITEDATA, 8'h5A);
        chk("single_pend",  bus.PENDING, 8'h08);
        tick();
        chk("single_we_off",  bus.WRITEENABLE, 0);
        chk("single_pend_off", bus.PENDING, 0);
        chk("single_wreg_hold", bus.WRITEREG, 3);
        chk("single_wdata_hold", bus.WRITEDATA, 8'h5A);

        // round robin from LAST=MEM
        #2 RESET = 1'b0;
        tick();
        #2 RESET = 1'b1;
        tick();
        bus.A_VALID = 1; bus.A_REG = 1; bus.A_DATA = 8'h11;
        bus.M_VALID = 1; bus.M_REG = 4; bus.M_DATA = 8'h44;
        sb_q.push_back({3'd1, 8'h11});
        sb_q.push_back({3'd4, 8'h44});
        sb_q.push_back({3'd2, 8'h22});
        sb_q.push_back({3'd5, 8'h55});
        wc = wr_count;
        tick();
        chk("rr_pend1", bus.PENDING, 8'h12);
        bus.A_REG = 2; bus.A_DATA = 8'h22;
        bus.M_REG = 5; bus.M_DATA = 8'h55;
        tick();
        bus.A_VALID = 0; bus.M_VALID = 0;
        chk("rr_pend2", bus.PENDING, 8'h36);
        wait_drain("rr_drain", 20);
        chk("rr_count", wr_count - wc, 4);
        if (wlog.size() >= 4) chk("rr_back2back", wlog[wlog.size()-1] - wlog[wlog.size()-4], 3);

        // BUSYWAIT stall with the ALU FIFO filling behind it
        bus.A_VALID = 1; bus.A_REG = 6; bus.A_DATA = 8'h66;
        sb_q.push_back({3'd6, 8'h66});
        tick();
        bus.A_VALID = 0;
        tick();
        bus.BUSYWAIT = 1;
        chk("stall_load_we",  bus.WRITEENABLE, 1);
        chk("stall_load_reg", bus.WRITEREG, 6);
        idx = 0;
        bus.A_VALID = 1; bus.A_REG = 7;
        for (int e = 0; e < 3; e++) begin
            bus.A_DATA = 8'h70 + 8'(idx);
            acc = bus.A_READY;
            if (acc) sb_q.push_back({3'd7, 8'h70 + 8'(idx)});
            tick();
            if (acc) idx++;
            chk("stall_we",    bus.WRITEENABLE, 1);
            chk("stall_wreg",  bus.WRITEREG, 6);
            chk("stall_wdata", bus.WRITEDATA, 8'h66);
        end
        chk("stall_ardy_full", bus.A_READY, 0);
        chk("stall_accepted", idx, 2);
        bus.BUSYWAIT = 0;
        bus.A_DATA = 8'h70 + 8'(idx);
        acc = bus.A_READY;
        if (acc) sb_q.push_back({3'd7, 8'h70 + 8'(idx)});
        tick();
        if (acc) idx++;
        chk("stall_next_reg",  bus.WRITEREG, 7);
        chk("stall_next_data", bus.WRITEDATA, 8'h70);
        n = 0;
        while (idx < 4 && n < 20) begin
            bus.A_DATA = 8'h70 + 8'(idx);
            acc = bus.A_READY;
            if (acc) sb_q.push_back({3'd7, 8'h70 + 8'(idx)});
            tick();
            if (acc) idx++;
            n++;
        end
        bus.A_VALID = 0;
        chk("stall_all_pushed", idx, 4);
        wait_drain("stall_drain", 20);

        // same register from both sources, LAST forced to MEM first
        bus.M_VALID = 1; bus.M_REG = 0; bus.M_DATA = 8'h01;
        sb_q.push_back({3'd0, 8'h01});
        tick();
        bus.M_VALID = 0;
        wait_drain("conf_pre_drain", 10);
        bus.A_VALID = 1; bus.A_REG = 2; bus.A_DATA = 8'hAA;
        bus.M_VALID = 1; bus.M_REG = 2; bus.M_DATA = 8'hBB;
        sb_q.push_back({3'd2, 8'hAA});
        sb_q.push_back({3'd2, 8'hBB});
        tick();
        bus.A_VALID = 0; bus.M_VALID = 0;
        chk("conf_pend0", bus.PENDING, 8'h04);
        tick();
        chk("conf_first",  bus.WRITEDATA, 8'hAA);
        chk("conf_pend1",  bus.PENDING, 8'h04);
        tick();
        chk("conf_second", bus.WRITEDATA, 8'hBB);
        chk("conf_pend2",  bus.PENDING, 8'h04);
        tick();
        chk("conf_pend3",  bus.PENDING, 0);
        chk("conf_we_off", bus.WRITEENABLE, 0);
        chk("conf_rf2",    rf[2], 8'hBB);

        // reset in the middle of traffic
        bus.BUSYWAIT = 1;
        bus.A_VALID = 1; bus.A_REG = 1; bus.A_DATA = 8'h31;
        bus.M_VALID = 1; bus.M_REG = 3; bus.M_DATA = 8'h33;
        tick();
        bus.A_REG = 5; bus.A_DATA = 8'h35;
        bus.M_REG = 6; bus.M_DATA = 8'h36;
        tick();
        bus.A_VALID = 0; bus.M_VALID = 0;
        chk("mid_we",   bus.WRITEENABLE, 1);
        chk("mid_wreg", bus.WRITEREG, 1);
        chk("mid_pend", bus.PENDING, 8'h6A);
        #2 RESET = 1'b0;
        #1;
        chk("mid_rst_we",   bus.WRITEENABLE, 0);
        chk("mid_rst_pend", bus.PENDING, 0);
        chk("mid_rst_ardy", bus.A_READY, 0);
        chk("mid_rst_mrdy", bus.M_READY, 0);
        bus.BUSYWAIT = 0;
        wc = wr_count;
        tick(); tick();
        #2 RESET = 1'b1;
        tick();
        chk("mid_rel_ardy", bus.A_READY, 1);
        chk("mid_rel_mrdy", bus.M_READY, 1);
        tick(); tick(); tick();
        chk("mid_no_writes", wr_count - wc, 0);
        chk("mid_we_idle",   bus.WRITEENABLE, 0);
        chk("mid_pend_idle", bus.PENDING, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
